// File: rtl/wilson_pkg.sv
// Shared constants and sign-magnitude Q15.16 arithmetic for the Wilson neuron solver.
// qmult/qadd wrap silently; callers rely on the values staying in range.
package wilson_pkg;

   localparam logic [31:0] C_INV   = 32'h00016710;
   localparam logic [31:0] A       = 32'h8028C99A;
   localparam logic [31:0] B       = 32'h80253454;
   localparam logic [31:0] C       = 32'h80208000;
   localparam logic [31:0] D       = 32'h000A89C1;
   localparam logic [31:0] E       = 32'h801DE666;
   localparam logic [31:0] F       = 32'h000C3E91;
   localparam logic [31:0] G       = 32'h0000B5E5;
   localparam logic [31:0] H       = 32'h800086BC;
   localparam logic [31:0] J       = 32'h00008A7C;
   localparam logic [31:0] DT      = 32'h00000042;
   localparam logic [31:0] DT_HALF = 32'h00000021;
   localparam logic [31:0] V_RESET = 32'h8000CCCD;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_HALF  = 3'd2;
   localparam logic [2:0] ST_FULL  = 3'd3;
   localparam logic [2:0] ST_WRITE = 3'd4;

   localparam logic [1:0] CFG_CUR = 2'd0;
   localparam logic [1:0] CFG_V   = 2'd1;
   localparam logic [1:0] CFG_R   = 2'd2;

   // Magnitudes multiply, the product is truncated toward zero, sign is the XOR.
   function automatic logic [31:0] qmult(input logic [31:0] a, input logic [31:0] b);
      logic [61:0] prod;
      prod = {31'd0, a[30:0]} * {31'd0, b[30:0]};
      return {a[31] ^ b[31], prod[46:16]};
   endfunction

   // Unlike signs subtract magnitudes; an exact cancellation yields +0.
   function automatic logic [31:0] qadd(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] res;
      res = '0;
      if (a[31] == b[31]) begin
         res[30:0] = a[30:0] + b[30:0];
         res[31]   = a[31];
      end else if (a[30:0] > b[30:0]) begin
         res[30:0] = a[30:0] - b[30:0];
         res[31]   = a[31];
      end else begin
         res[30:0] = b[30:0] - a[30:0];
         res[31]   = (res[30:0] != 31'd0) ? b[31] : 1'b0;
      end
      return res;
   endfunction

endpackage

// File: rtl/wilson_deriv.sv
// Combinational Wilson derivatives (dv, dr) at one (v, r, current) point.
module wilson_deriv
   import wilson_pkg::*;
(
   input  logic [31:0] v,
   input  logic [31:0] r,
   input  logic [31:0] cur,
   output logic [31:0] dv,
   output logic [31:0] dr
);

   logic [31:0] v2;
   logic [31:0] v3;
   logic [31:0] rv;

   assign v2 = qmult(v, v);
   assign v3 = qmult(v2, v);
   assign rv = qmult(r, v);

   // Terms are paired into a shallow adder tree to shorten the v-cubed path.
   assign dv = qadd(qadd(qadd(qmult(C_INV, cur), qmult(A, v3)),
                         qadd(qmult(B, v2), qmult(C, rv))),
                    qadd(qadd(qmult(D, v), qmult(E, r)), F));

   assign dr = qadd(qadd(qmult(G, v), qmult(H, r)), J);

endmodule

// File: rtl/wilson_scheduler.sv
// Time-multiplexes one midpoint-derivative datapath across NUM_NEURONS neurons,
// one LOAD/HALF/FULL/WRITE pass per neuron per time step, in index order.
module wilson_scheduler
   import wilson_pkg::*;
#(
   parameter int NUM_NEURONS = 4,
   parameter int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
   parameter int STEP_W      = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [STEP_W-1:0] steps,
   output logic              busy,
   output logic              done,
   input  logic              cfg_we,
   input  logic [1:0]        cfg_sel,
   input  logic [IDX_W-1:0]  cfg_addr,
   input  logic [31:0]       cfg_data,
   output logic              out_valid,
   output logic [IDX_W-1:0]  out_idx,
   output logic [31:0]       out_v,
   output logic [31:0]       out_r
);

   logic [2:0]        state;
   logic [IDX_W-1:0]  idx;
   logic [STEP_W-1:0] step_cnt;
   logic [STEP_W-1:0] steps_lat;
   logic [31:0]       v0, r0, i0, vh, rh, v1, r1;
   logic [31:0]       v_mem   [NUM_NEURONS];
   logic [31:0]       r_mem   [NUM_NEURONS];
   logic [31:0]       cur_mem [NUM_NEURONS];
   logic [31:0]       d_v_in, d_r_in, dv, dr;
   logic              last_idx, last_step, cfg_hit;

   // HALF evaluates at the stored state, FULL at the midpoint estimate.
   assign d_v_in = (state == ST_HALF) ? v0 : vh;
   assign d_r_in = (state == ST_HALF) ? r0 : rh;

   wilson_deriv u_deriv (
      .v   (d_v_in),
      .r   (d_r_in),
      .cur (i0),
      .dv  (dv),
      .dr  (dr)
   );

   assign last_idx  = (idx == IDX_W'(NUM_NEURONS - 1));
   assign last_step = ((step_cnt + STEP_W'(1)) == steps_lat);
   assign cfg_hit   = cfg_we && (int'(cfg_addr) < NUM_NEURONS);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         idx       <= '0;
         step_cnt  <= '0;
         steps_lat <= '0;
         v0        <= '0;
         r0        <= '0;
         i0        <= '0;
         vh        <= '0;
         rh        <= '0;
         v1        <= '0;
         r1        <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_v     <= '0;
         out_r     <= '0;
      end else begin
         done      <= 1'b0;
         out_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (steps != '0) begin
                     steps_lat <= steps;
                     idx       <= '0;
                     step_cnt  <= '0;
                     busy      <= 1'b1;
                     state     <= ST_LOAD;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               v0    <= v_mem[idx];
               r0    <= r_mem[idx];
               i0    <= cur_mem[idx];
               state <= ST_HALF;
            end
            ST_HALF: begin
               vh    <= qadd(v0, qmult(dv, DT_HALF));
               rh    <= qadd(r0, qmult(dr, DT_HALF));
               state <= ST_FULL;
            end
            ST_FULL: begin
               v1    <= qadd(v0, qmult(dv, DT));
               r1    <= qadd(r0, qmult(dr, DT));
               state <= ST_WRITE;
            end
            ST_WRITE: begin
               out_valid <= 1'b1;
               out_idx   <= idx;
               out_v     <= v1;
               out_r     <= r1;
               if (!last_idx) begin
                  idx   <= idx + IDX_W'(1);
                  state <= ST_LOAD;
               end else begin
                  idx      <= '0;
                  step_cnt <= step_cnt + STEP_W'(1);
                  if (last_step) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= ST_IDLE;
                  end else begin
                     state <= ST_LOAD;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Solver write-back only happens while busy, and host v/r writes only while idle,
   // so the two never collide on the same entry.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NUM_NEURONS; k++) begin
            v_mem[k]   <= V_RESET;
            r_mem[k]   <= '0;
            cur_mem[k] <= '0;
         end
      end else begin
         if (state == ST_WRITE) begin
            v_mem[idx] <= v1;
            r_mem[idx] <= r1;
         end
         if (cfg_hit) begin
            case (cfg_sel)
               CFG_CUR: cur_mem[cfg_addr] <= cfg_data;
               CFG_V:   if (!busy) v_mem[cfg_addr] <= cfg_data;
               CFG_R:   if (!busy) r_mem[cfg_addr] <= cfg_data;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_wilson_scheduler.sv
// Directed bench for wilson_scheduler; a value-domain midpoint model checks every update.
module tb_wilson_scheduler;

   localparam int N = 4;

   localparam logic [31:0] K_CINV = 32'h00016710;
   localparam logic [31:0] K_A    = 32'h8028C99A;
   localparam logic [31:0] K_B    = 32'h80253454;
   localparam logic [31:0] K_C    = 32'h80208000;
   localparam logic [31:0] K_D    = 32'h000A89C1;
   localparam logic [31:0] K_E    = 32'h801DE666;
   localparam logic [31:0] K_F    = 32'h000C3E91;
   localparam logic [31:0] K_G    = 32'h0000B5E5;
   localparam logic [31:0] K_H    = 32'h800086BC;
   localparam logic [31:0] K_J    = 32'h00008A7C;
   localparam logic [31:0] K_DT   = 32'h00000042;
   localparam logic [31:0] K_DTH  = 32'h00000021;
   localparam logic [31:0] K_VRST = 32'h8000CCCD;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] steps = '0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_sel = '0;
   logic [1:0]  cfg_addr = '0;
   logic [31:0] cfg_data = '0;
   logic        busy, done, out_valid;
   logic [1:0]  out_idx;
   logic [31:0] out_v, out_r;

   int     check_count = 0;
   int     pass_count = 0;
   longint mv [N];
   longint mr [N];
   longint mc [N];
   int     exp_idx = 0;
   int     exp_left = 0;
   int     ov_count = 0;

   wilson_scheduler #(.NUM_NEURONS(N), .IDX_W(2), .STEP_W(16)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .steps     (steps),
      .busy      (busy),
      .done      (done),
      .cfg_we    (cfg_we),
      .cfg_sel   (cfg_sel),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .out_valid (out_valid),
      .out_idx   (out_idx),
      .out_v     (out_v),
      .out_r     (out_r)
   );

   always #5 clock = ~clock;

   function automatic longint sm2v(input logic [31:0] x);
      longint mag;
      mag = 0;
      mag[30:0] = x[30:0];
      return x[31] ? -mag : mag;
   endfunction

   function automatic logic [31:0] v2sm(input longint x);
      longint      mag;
      logic [31:0] res;
      mag = (x < 0) ? -x : x;
      res = {1'b0, mag[30:0]};
      res[31] = (x < 0);
      return res;
   endfunction

   // Real-valued product scaled by 2^-16, truncated toward zero.
   function automatic longint qm(input longint a, input longint b);
      longint p, mag;
      p = a * b;
      mag = (p < 0) ? -p : p;
      mag = (mag >>> 16) & 64'h7FFF_FFFF;
      return (p < 0) ? -mag : mag;
   endfunction

   function automatic longint dv_f(input longint v, input longint r, input longint i);
      return qm(sm2v(K_CINV), i) + qm(sm2v(K_A), qm(qm(v, v), v)) + qm(sm2v(K_B), qm(v, v))
           + qm(sm2v(K_C), qm(r, v)) + qm(sm2v(K_D), v) + qm(sm2v(K_E), r) + sm2v(K_F);
   endfunction

   function automatic longint dr_f(input longint v, input longint r);
      return qm(sm2v(K_G), v) + qm(sm2v(K_H), r) + sm2v(K_J);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         mv[k] = sm2v(K_VRST);
         mr[k] = 0;
         mc[k] = 0;
      end
      exp_idx = 0;
      exp_left = 0;
   endtask

   task automatic model_update(input int k, output logic [31:0] ev, output logic [31:0] er);
      longint v, r, i, vh, rh;
      v = mv[k];
      r = mr[k];
      i = mc[k];
      vh = v + qm(dv_f(v, r, i), sm2v(K_DTH));
      rh = r + qm(dr_f(v, r), sm2v(K_DTH));
      mv[k] = v + qm(dv_f(vh, rh, i), sm2v(K_DT));
      mr[k] = r + qm(dr_f(vh, rh), sm2v(K_DT));
      ev = v2sm(mv[k]);
      er = v2sm(mr[k]);
   endtask

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual === expected) pass_count++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
   endtask

   // Every out_valid pulse is checked against the model's next neuron in index order.
   always @(negedge clock) begin
      logic [31:0] ev, er;
      if (reset_n && out_valid) begin
         ov_count++;
         if (exp_left == 0) begin
            check_output("unexpected_out_valid", 32'(out_valid), 32'd0);
         end else begin
            check_output("out_idx", 32'(out_idx), 32'(exp_idx));
            model_update(exp_idx, ev, er);
            check_output("out_v", out_v, ev);
            check_output("out_r", out_r, er);
            exp_idx = (exp_idx + 1) % N;
            exp_left--;
         end
      end
   end

   task automatic apply_stimulus(input int n_steps, input int n_updates);
      @(posedge clock); #1;
      start = 1'b1;
      steps = 16'(n_steps);
      exp_left += n_updates;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   task automatic cfg_write(input logic [1:0] sel, input int addr, input logic [31:0] data, input bit taken);
      @(posedge clock); #1;
      cfg_we = 1'b1;
      cfg_sel = sel;
      cfg_addr = 2'(addr);
      cfg_data = data;
      @(posedge clock); #1;
      cfg_we = 1'b0;
      if (taken) begin
         case (sel)
            2'd0: mc[addr] = sm2v(data);
            2'd1: mv[addr] = sm2v(data);
            2'd2: mr[addr] = sm2v(data);
            default: ;
         endcase
      end
   endtask

   task automatic wait_done(input int limit, output int busy_cycles, output bit seen, output bit ov_at_done);
      busy_cycles = 0;
      seen = 1'b0;
      ov_at_done = 1'b0;
      for (int c = 0; c < limit && !seen; c++) begin
         @(negedge clock);
         if (busy) busy_cycles++;
         if (done) begin
            seen = 1'b1;
            ov_at_done = out_valid;
         end
      end
      #1;
   endtask

   task automatic wait_valid(input int want_idx, input int limit, output bit seen);
      seen = 1'b0;
      for (int c = 0; c < limit && !seen; c++) begin
         @(negedge clock);
         if (out_valid && (want_idx < 0 || int'(out_idx) == want_idx)) seen = 1'b1;
      end
   endtask

   task automatic run_and_check(input string tag, input int n_steps, input int limit);
      int bc, ov0;
      bit seen, ovd;
      ov0 = ov_count;
      apply_stimulus(n_steps, N * n_steps);
      wait_done(limit, bc, seen, ovd);
      check_output({tag, "_done_seen"}, 32'(seen), 32'd1);
      check_output({tag, "_busy_cycles"}, 32'(bc), 32'(4 * N * n_steps));
      check_output({tag, "_valid_at_done"}, 32'(ovd), 32'd1);
      check_output({tag, "_valid_count"}, 32'(ov_count - ov0), 32'(N * n_steps));
   endtask

   initial begin
      int  busy_hits, ov0;
      bit  seen;

      // Hand-computed anchors for the model arithmetic.
      check_output("model_mul", v2sm(qm(sm2v(32'h00020000), sm2v(32'h80018000))), 32'h80030000);
      check_output("model_trunc", v2sm(qm(sm2v(32'h00000100), sm2v(32'h00000100))), 32'h00000001);
      check_output("model_sub", v2sm(sm2v(32'h00010000) + sm2v(32'h80030000)), 32'h80020000);
      check_output("model_dr0", v2sm(dr_f(0, 0)), 32'h00008A7C);
      check_output("model_dv0", v2sm(dv_f(0, 0, sm2v(32'h00010000))), 32'h000DA5A1);

      model_reset();
      repeat (3) @(posedge clock);
      #1;
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_done", 32'(done), 32'd0);
      check_output("rst_out_valid", 32'(out_valid), 32'd0);
      check_output("rst_out_idx", 32'(out_idx), 32'd0);
      check_output("rst_out_v", out_v, 32'd0);
      check_output("rst_out_r", out_r, 32'd0);
      reset_n = 1'b1;

      run_and_check("s1", 1, 100);
      @(negedge clock);
      check_output("s1_done_one_cycle", 32'(done), 32'd0);

      cfg_write(2'd0, 0, 32'h00010000, 1'b1);
      cfg_write(2'd0, 1, 32'h00020000, 1'b1);
      cfg_write(2'd0, 2, 32'h80010000, 1'b1);
      cfg_write(2'd0, 3, 32'h00008000, 1'b1);
      run_and_check("s2", 3, 300);

      ov0 = ov_count;
      apply_stimulus(0, 0);
      @(negedge clock);
      check_output("s3_done_next", 32'(done), 32'd1);
      check_output("s3_busy_low", 32'(busy), 32'd0);
      busy_hits = 0;
      repeat (6) begin
         @(negedge clock);
         if (busy || done) busy_hits++;
      end
      check_output("s3_quiet", 32'(busy_hits), 32'd0);
      check_output("s3_no_valid", 32'(ov_count - ov0), 32'd0);

      begin
         int bc;
         bit sd, ovd;
         ov0 = ov_count;
         apply_stimulus(2, 2 * N);
         repeat (2) @(posedge clock);
         cfg_write(2'd1, 2, 32'h00010000, 1'b0);
         apply_stimulus(5, 0);
         wait_valid(2, 40, seen);
         check_output("s4_saw_idx2", 32'(seen), 32'd1);
         cfg_write(2'd0, 2, 32'h00050000, 1'b1);
         wait_done(200, bc, sd, ovd);
         check_output("s4_done_seen", 32'(sd), 32'd1);
         check_output("s4_valid_count", 32'(ov_count - ov0), 32'(2 * N));
         check_output("s4_valid_at_done", 32'(ovd), 32'd1);
      end
      cfg_write(2'd1, 2, 32'h00010000, 1'b1);
      run_and_check("s4b", 1, 100);

      apply_stimulus(3, 3 * N);
      wait_valid(-1, 60, seen);
      check_output("s5_saw_valid", 32'(seen), 32'd1);
      check_output("s5_busy_before", 32'(busy), 32'd1);
      #1;
      reset_n = 1'b0;
      #1;
      check_output("s5_busy_drop", 32'(busy), 32'd0);
      check_output("s5_valid_drop", 32'(out_valid), 32'd0);
      check_output("s5_done_low", 32'(done), 32'd0);
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      run_and_check("s5_rerun", 1, 100);

      $display("[TB] %0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
